// File: rtl/adder_arbiter_if.sv
// Request/response bundle for the shared-adder arbiter.
// The master side owns the request operands and the response ready;
// the slave side (the arbiter) owns the grants and the registered result.
interface adder_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 3,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_y;
    logic                  rsp_cout;
    logic [IDW-1:0]        rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_cout, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_cout, rsp_id
    );
endinterface

// File: rtl/adder_arbiter.sv
// Shared unsigned adder with a round-robin arbiter in front of it.
// NREQ requesters offer operand pairs; one is granted per accept cycle,
// its operands are muxed into a single adder, and the sum, carry-out and
// owner ID are registered onto one backpressured response channel.

// Plain ripple-style unsigned adder; carry-out is the MSB of the
// zero-extended sum.
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y,
    output logic             o_cout
);
    assign {o_cout, o_y} = {1'b0, i_a} + {1'b0, i_b};
endmodule

module adder_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 3,
    parameter int IDW   = 2
) (
    input  logic             clk,
    input  logic             reset,
    adder_arbiter_if.slave   bus
);
    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDW-1:0]    r_rr_ptr;
    logic              r_rsp_valid;
    logic [WIDTH-1:0]  r_rsp_y;
    logic              r_rsp_cout;
    logic [IDW-1:0]    r_rsp_id;

    logic              w_any;
    logic [IDW-1:0]    w_winner;
    logic [NREQ-1:0]   w_grant;
    logic              w_can_accept;
    logic              w_accept;
    logic [IDW-1:0]    w_ptr_nxt;
    logic [WIDTH-1:0]  w_op_a;
    logic [WIDTH-1:0]  w_op_b;
    logic [WIDTH-1:0]  w_sum;
    logic              w_cout;

    // Round-robin search: first pass covers rr_ptr..NREQ-1, the second
    // pass only fires when nothing was found there, so it covers the wrap.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_grant  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_any && bus.req_valid[i] && (IDW'(i) >= r_rr_ptr)) begin
                w_any      = 1'b1;
                w_winner   = IDW'(i);
                w_grant[i] = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_any && bus.req_valid[i]) begin
                w_any      = 1'b1;
                w_winner   = IDW'(i);
                w_grant[i] = 1'b1;
            end
        end
    end

    // Steer the winner's operands into the single shared adder.
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == w_winner) begin
                w_op_a = bus.req_a[i*WIDTH +: WIDTH];
                w_op_b = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    adder #(.WIDTH(WIDTH)) u_adder (
        .i_a    (w_op_a),
        .i_b    (w_op_b),
        .o_y    (w_sum),
        .o_cout (w_cout)
    );

    // A new operation may enter when the output slot is empty or is
    // being drained this cycle; grants are suppressed during reset.
    assign w_can_accept  = (r_state == S_IDLE) || ((r_state == S_RESP) && bus.rsp_ready);
    assign w_accept      = w_can_accept && w_any && !reset;
    assign w_ptr_nxt     = (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + IDW'(1);
    assign bus.req_ready = w_accept ? w_grant : '0;

    // Next-state logic for the IDLE/RESP controller.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_RESP;
            S_RESP: begin
                if (w_accept)          w_state_nxt = S_RESP;
                else if (bus.rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, pointer and response registers; the pointer moves only when
    // a request is actually accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_y     <= '0;
            r_rsp_cout  <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rsp_y     <= w_sum;
                r_rsp_cout  <= w_cout;
                r_rsp_id    <= w_winner;
                r_rsp_valid <= 1'b1;
                r_rr_ptr    <= w_ptr_nxt;
            end else if ((r_state == S_RESP) && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_y     = r_rsp_y;
    assign bus.rsp_cout  = r_rsp_cout;
    assign bus.rsp_id    = r_rsp_id;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: 3 requesters, 32-bit operands.
module tb_adder_arbiter;
    localparam int WIDTH = 32;
    localparam int NREQ  = 3;
    localparam int IDW   = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    adder_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

    adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.req_valid = 3'b000;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        reset         = 1'b1;
        tick();
        tick();
        bus.req_valid = 3'b001;
        #1;
        n_total++; if (bus.req_ready !== 3'b000) $display("FAIL reset_ready got %b exp 000", bus.req_ready); else n_pass++;
        n_total++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.rsp_valid); else n_pass++;
        n_total++; if (bus.rsp_y !== 32'h0) $display("FAIL reset_y got %h exp 0", bus.rsp_y); else n_pass++;
        n_total++; if (bus.rsp_cout !== 1'b0) $display("FAIL reset_cout got %b exp 0", bus.rsp_cout); else n_pass++;
        n_total++; if (bus.rsp_id !== 2'd0) $display("FAIL reset_id got %0d exp 0", bus.rsp_id); else n_pass++;
        bus.req_valid = 3'b000;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single();
        bus.req_a[0*WIDTH +: WIDTH] = 32'h0000_1000;
        bus.req_b[0*WIDTH +: WIDTH] = 32'd4;
        bus.req_valid = 3'b001;
        bus.rsp_ready = 1'b1;
        #1;
        n_total++; if (bus.req_ready !== 3'b001) $display("FAIL single_ready got %b exp 001", bus.req_ready); else n_pass++;
        tick();
        bus.req_valid = 3'b000;
        n_total++; if (bus.rsp_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", bus.rsp_valid); else n_pass++;
        n_total++; if (bus.rsp_y !== 32'h0000_1004) $display("FAIL single_y got %h exp 00001004", bus.rsp_y); else n_pass++;
        n_total++; if (bus.rsp_cout !== 1'b0) $display("FAIL single_cout got %b exp 0", bus.rsp_cout); else n_pass++;
        n_total++; if (bus.rsp_id !== 2'd0) $display("FAIL single_id got %0d exp 0", bus.rsp_id); else n_pass++;
        tick();
        n_total++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_retire got %b exp 0", bus.rsp_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  exp_rdy;
        logic [31:0] exp_y;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*WIDTH +: WIDTH] = 32'(i);
            bus.req_b[i*WIDTH +: WIDTH] = 32'(10 * i);
        end
        bus.req_valid = 3'b111;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_rdy = 3'(1 << (k % 3));
            exp_y   = 32'(11 * (k % 3));
            n_total++; if (bus.req_ready !== exp_rdy) $display("FAIL b2b_ready[%0d] got %b exp %b", k, bus.req_ready, exp_rdy); else n_pass++;
            @(posedge clk);
            #1;
            n_total++; if (bus.rsp_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got %b exp 1", k, bus.rsp_valid); else n_pass++;
            n_total++; if (bus.rsp_id !== 2'(k % 3)) $display("FAIL b2b_id[%0d] got %0d exp %0d", k, bus.rsp_id, k % 3); else n_pass++;
            n_total++; if (bus.rsp_y !== exp_y) $display("FAIL b2b_y[%0d] got %0d exp %0d", k, bus.rsp_y, exp_y); else n_pass++;
        end
        bus.req_valid = 3'b000;
        tick();
    endtask

    task automatic test_overflow();
        bus.req_a[1*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
        bus.req_b[1*WIDTH +: WIDTH] = 32'd1;
        bus.req_valid = 3'b010;
        bus.rsp_ready = 1'b1;
        #1;
        n_total++; if (bus.req_ready !== 3'b010) $display("FAIL ovf_ready1 got %b exp 010", bus.req_ready); else n_pass++;
        tick();
        n_total++; if (bus.rsp_y !== 32'h0) $display("FAIL ovf_y1 got %h exp 0", bus.rsp_y); else n_pass++;
        n_total++; if (bus.rsp_cout !== 1'b1) $display("FAIL ovf_cout1 got %b exp 1", bus.rsp_cout); else n_pass++;
        n_total++; if (bus.rsp_id !== 2'd1) $display("FAIL ovf_id1 got %0d exp 1", bus.rsp_id); else n_pass++;
        bus.req_a[2*WIDTH +: WIDTH] = 32'h7FFF_FFFF;
        bus.req_b[2*WIDTH +: WIDTH] = 32'd1;
        bus.req_valid = 3'b100;
        #1;
        n_total++; if (bus.req_ready !== 3'b100) $display("FAIL ovf_ready2 got %b exp 100", bus.req_ready); else n_pass++;
        tick();
        n_total++; if (bus.rsp_y !== 32'h8000_0000) $display("FAIL ovf_y2 got %h exp 80000000", bus.rsp_y); else n_pass++;
        n_total++; if (bus.rsp_cout !== 1'b0) $display("FAIL ovf_cout2 got %b exp 0", bus.rsp_cout); else n_pass++;
        n_total++; if (bus.rsp_id !== 2'd2) $display("FAIL ovf_id2 got %0d exp 2", bus.rsp_id); else n_pass++;
        bus.req_valid = 3'b000;
        tick();
    endtask

    task automatic test_backpressure();
        bus.req_a[0*WIDTH +: WIDTH] = 32'd5;
        bus.req_b[0*WIDTH +: WIDTH] = 32'd3;
        bus.req_a[2*WIDTH +: WIDTH] = 32'd20;
        bus.req_b[2*WIDTH +: WIDTH] = 32'd22;
        bus.req_valid = 3'b001;
        bus.rsp_ready = 1'b0;
        tick();
        bus.req_valid = 3'b100;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_total++; if (bus.req_ready !== 3'b000) $display("FAIL bp_ready[%0d] got %b exp 000", k, bus.req_ready); else n_pass++;
            n_total++; if (bus.rsp_y !== 32'd8) $display("FAIL bp_y[%0d] got %0d exp 8", k, bus.rsp_y); else n_pass++;
            n_total++; if (bus.rsp_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %b exp 1", k, bus.rsp_valid); else n_pass++;
            tick();
        end
        n_total++; if (bus.rsp_id !== 2'd0) $display("FAIL bp_id_hold got %0d exp 0", bus.rsp_id); else n_pass++;
        bus.rsp_ready = 1'b1;
        #1;
        n_total++; if (bus.req_ready !== 3'b100) $display("FAIL bp_release got %b exp 100", bus.req_ready); else n_pass++;
        tick();
        n_total++; if (bus.rsp_y !== 32'd42) $display("FAIL bp_next_y got %0d exp 42", bus.rsp_y); else n_pass++;
        n_total++; if (bus.rsp_id !== 2'd2) $display("FAIL bp_next_id got %0d exp 2", bus.rsp_id); else n_pass++;
        bus.req_valid = 3'b000;
        tick();
    endtask

    task automatic test_ptr_wrap();
        bus.req_a[0*WIDTH +: WIDTH] = 32'd1;
        bus.req_b[0*WIDTH +: WIDTH] = 32'd2;
        bus.req_a[2*WIDTH +: WIDTH] = 32'd100;
        bus.req_b[2*WIDTH +: WIDTH] = 32'd200;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 3'b100;
        tick();
        bus.req_valid = 3'b101;
        #1;
        n_total++; if (bus.req_ready !== 3'b001) $display("FAIL wrap_ready0 got %b exp 001", bus.req_ready); else n_pass++;
        tick();
        n_total++; if (bus.rsp_id !== 2'd0) $display("FAIL wrap_id0 got %0d exp 0", bus.rsp_id); else n_pass++;
        n_total++; if (bus.rsp_y !== 32'd3) $display("FAIL wrap_y0 got %0d exp 3", bus.rsp_y); else n_pass++;
        #1;
        n_total++; if (bus.req_ready !== 3'b100) $display("FAIL wrap_ready2 got %b exp 100", bus.req_ready); else n_pass++;
        tick();
        n_total++; if (bus.rsp_id !== 2'd2) $display("FAIL wrap_id2 got %0d exp 2", bus.rsp_id); else n_pass++;
        n_total++; if (bus.rsp_y !== 32'd300) $display("FAIL wrap_y2 got %0d exp 300", bus.rsp_y); else n_pass++;
        bus.req_valid = 3'b000;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.req_a[1*WIDTH +: WIDTH] = 32'd7;
        bus.req_b[1*WIDTH +: WIDTH] = 32'd7;
        bus.req_a[2*WIDTH +: WIDTH] = 32'd9;
        bus.req_b[2*WIDTH +: WIDTH] = 32'd1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 3'b010;
        tick();
        bus.req_valid = 3'b000;
        n_total++; if (bus.rsp_y !== 32'd14) $display("FAIL mid_pending_y got %0d exp 14", bus.rsp_y); else n_pass++;
        reset = 1'b1;
        bus.req_valid = 3'b110;
        #1;
        n_total++; if (bus.req_ready !== 3'b000) $display("FAIL mid_ready_in_reset got %b exp 000", bus.req_ready); else n_pass++;
        tick();
        n_total++; if (bus.rsp_valid !== 1'b0) $display("FAIL mid_valid got %b exp 0", bus.rsp_valid); else n_pass++;
        n_total++; if (bus.rsp_y !== 32'd0) $display("FAIL mid_y got %0d exp 0", bus.rsp_y); else n_pass++;
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        n_total++; if (bus.req_ready !== 3'b010) $display("FAIL mid_first_grant got %b exp 010", bus.req_ready); else n_pass++;
        tick();
        n_total++; if (bus.rsp_id !== 2'd1) $display("FAIL mid_id1 got %0d exp 1", bus.rsp_id); else n_pass++;
        #1;
        n_total++; if (bus.req_ready !== 3'b100) $display("FAIL mid_second_grant got %b exp 100", bus.req_ready); else n_pass++;
        tick();
        n_total++; if (bus.rsp_id !== 2'd2) $display("FAIL mid_id2 got %0d exp 2", bus.rsp_id); else n_pass++;
        n_total++; if (bus.rsp_y !== 32'd10) $display("FAIL mid_y2 got %0d exp 10", bus.rsp_y); else n_pass++;
        bus.req_valid = 3'b000;
        tick();
        n_total++; if (bus.rsp_valid !== 1'b0) $display("FAIL mid_idle got %b exp 0", bus.rsp_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_backpressure();
        test_ptr_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one `adder #(WIDTH)` instance among NREQ requesters, e.g. PC+4 fetch, branch-target and address-generation units.
- Each requester presents two operands with a valid/ready handshake.
- A round-robin scheduler grants one requester per accept cycle.
- The registered sum, carry-out and requester ID are returned on a single response channel with backpressure.

Parameters:
- WIDTH, 32, operand/result width in bits.
- NREQ, 3, number of requesters (2..8).
- IDW, 2, width of requester ID; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  bit i = requester i has operands pending.
- req_a  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B; same packing as req_a.
- req_ready  output  NREQ  one-hot (or zero) grant; the operands of requester i are consumed in the cycle where req_valid[i] && req_ready[i].
- rsp_valid  output  1  registered result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_y  output  WIDTH  registered sum, (a+b) mod 2**WIDTH.
- rsp_cout  output  1  registered carry-out of a+b.
- rsp_id  output  IDW  index of the requester that owns rsp_y.

Behaviour:
- Clocking and reset:
  - Reset is synchronous and active-high; all state updates on the rising edge of clk.
  - While reset=1: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_y=0, rsp_cout=0, rsp_id=0, req_ready=0.
- State machine: two states, IDLE and RESP.
- Accept condition:
  - can_accept = (state==IDLE) || (state==RESP && rsp_ready).
  - req_ready is combinational: it is the one-hot grant vector when can_accept and any req_valid is set, otherwise 0.
  - req_ready never has more than one bit set.
  - req_ready[i] is never 1 unless req_valid[i] is 1.
- Round-robin grant:
  - Search starts at index rr_ptr and proceeds upward, wrapping NREQ-1 -> 0.
  - The first index with req_valid set wins.
- On an accept edge:
  - rsp_y <= a+b of the winner, computed through the single shared adder instance; the operands are muxed into it.
  - rsp_cout <= bit WIDTH of the zero-extended (WIDTH+1)-bit sum.
  - rsp_id <= winner index.
  - rsp_valid <= 1; state <= RESP.
  - rr_ptr <= (winner+1) mod NREQ, wrapping to 0 when winner = NREQ-1.
- Transitions:
  - IDLE, no req_valid: stay in IDLE; rsp_valid=0.
  - IDLE, some req_valid: accept; go to RESP. Result is visible on the next cycle (latency 1).
  - RESP, rsp_ready=0: hold rsp_y, rsp_cout and rsp_id stable; req_ready=0.
  - RESP, rsp_ready=1, some req_valid: the response retires and the new request is accepted in the same cycle; stay in RESP with the new result. This gives back-to-back throughput of 1 operation per cycle.
  - RESP, rsp_ready=1, no req_valid: rsp_valid <= 0; go to IDLE.
- rr_ptr changes only on accept edges, never on response retirement alone.
- Fairness: a requester holding req_valid is granted within NREQ accept cycles.
- A requester may deassert req_valid before it is granted; no state is left behind.
- Reset asserted mid-operation (RESP, result pending): the result is discarded, rsp_valid=0 on the next cycle, and rr_ptr returns to 0.
- Arithmetic is unsigned modulo 2**WIDTH; signed interpretation is left to the consumer.
  - Example: 0xFFFF_FFFF + 1 gives rsp_y=0, rsp_cout=1.

Test Plan:
1. Reset, then only req 0 valid with a=0x0000_1000, b=4, rsp_ready=1 -> req_ready=001 in the same cycle; next cycle rsp_valid=1, rsp_y=0x0000_1004, rsp_cout=0, rsp_id=0.
2. All three valid continuously, rsp_ready=1, operands a=i, b=10*i -> grants 0,1,2,0,1,2 on consecutive cycles; rsp_y sequence 0,11,22,0,11,22; rsp_valid stays high.
3. Overflow: req 1 with a=0xFFFF_FFFF, b=1 -> rsp_y=0, rsp_cout=1, rsp_id=1. Req 2 with a=0x7FFF_FFFF, b=1 -> rsp_y=0x8000_0000, rsp_cout=0.
4. Backpressure: result 5+3 pending with rsp_ready=0 for 4 cycles while req 2 is valid -> rsp_y=8 held stable and req_ready=000 throughout. In the cycle rsp_ready=1, req_ready=100; the next result comes from req 2.
5. Pointer wrap: after a grant to req 2, both req 0 and req 2 valid -> req 0 is granted first, then req 2.
6. Reset mid-RESP with rsp_ready=0 -> next cycle rsp_valid=0, state IDLE. With req 1 and req 2 both valid afterwards, req 1 is granted first (rr_ptr=0 and req 0 idle).
